// File: rtl/sprite_pkg.sv
// sprite_pkg: geometry, widths and helpers shared by the sprite fetch scheduler.
package sprite_pkg;
  localparam int NUM_SPRITES = 4;
  localparam int SPR_W = 35;
  localparam int SPR_H = 58;
  localparam int SPR_X0 = 0;
  localparam int SPR_Y0 = 82;
  localparam int SPR_DY = 64;
  localparam int ROM_AW = 13;
  localparam int IDX_W = 1;
  localparam int BLINK_FRAMES = 15;
  localparam int BLINK_W = $clog2(BLINK_FRAMES + 1);
  localparam int SPR_SIZE = SPR_W * SPR_H;
  typedef logic [2:0] sprite_id_t;
  typedef logic [IDX_W-1:0] pix_idx_t;
  typedef logic [ROM_AW-1:0] rom_addr_t;
  function automatic int spr_base(input int i);
    return i * SPR_SIZE;
  endfunction
  function automatic int spr_top(input int i);
    return SPR_Y0 + i * SPR_DY;
  endfunction
endpackage

// File: rtl/sprite_slot_decode.sv
// sprite_slot_decode: finds the lowest-index slot covering a pixel and its ROM address.
module sprite_slot_decode
  import sprite_pkg::*;
(
  input  logic [9:0] draw_x,
  input  logic [9:0] draw_y,
  output logic       hit,
  output sprite_id_t id,
  output rom_addr_t  address
);
  logic [31:0] x, y;
  logic [NUM_SPRITES-1:0] slot_hit;
  rom_addr_t slot_addr [NUM_SPRITES];
  assign x = 32'(draw_x);
  assign y = 32'(draw_y);
  for (genvar i = 0; i < NUM_SPRITES; i++) begin : g_slot
    localparam int TOP = spr_top(i);
    localparam int BASE = spr_base(i);
    logic [31:0] full;
    assign slot_hit[i] = x >= 32'(SPR_X0) && x < 32'(SPR_X0 + SPR_W) &&
                         y >= 32'(TOP) && y < 32'(TOP + SPR_H);
    assign full = 32'(BASE) + (x - 32'(SPR_X0)) + (y - 32'(TOP)) * 32'(SPR_W);
    assign slot_addr[i] = full[ROM_AW-1:0];
  end
  // Scanning downwards lets the lowest matching index overwrite the others.
  always_comb begin
    hit = 1'b0;
    id = '0;
    address = '0;
    for (int k = NUM_SPRITES - 1; k >= 0; k--)
      if (slot_hit[k]) begin
        hit = 1'b1;
        id = sprite_id_t'(k);
        address = slot_addr[k];
      end
  end
endmodule

// File: rtl/sprite_fetch_scheduler.sv
// sprite_fetch_scheduler: two-stage shared-ROM fetch for stacked track sprites with frame-latched blinking highlight.
module sprite_fetch_scheduler
  import sprite_pkg::*;
(
  input  logic       vga_clk,
  input  logic       reset_n,
  input  logic [9:0] DrawX,
  input  logic [9:0] DrawY,
  input  logic       blank,
  input  logic [2:0] track_sel,
  output rom_addr_t  rom_address,
  input  pix_idx_t   rom_q,
  output logic       pix_hit,
  output sprite_id_t pix_id,
  output pix_idx_t   pix_index,
  output logic       pix_highlight,
  output logic       pix_blank
);
  logic d_hit, vis, frame_start, last_frame;
  sprite_id_t d_id, id1, sel;
  rom_addr_t d_addr;
  logic hit1, blank1, blink_on, sel_on;
  logic [BLINK_W-1:0] cnt;
  sprite_slot_decode u_decode (
    .draw_x (DrawX),
    .draw_y (DrawY),
    .hit    (d_hit),
    .id     (d_id),
    .address(d_addr)
  );
  assign vis = d_hit & blank;
  assign frame_start = DrawX == 10'd0 && DrawY == 10'd0;
  assign last_frame = cnt == BLINK_W'(BLINK_FRAMES - 1);
  always_ff @(posedge vga_clk or negedge reset_n)
    if (!reset_n) begin
      rom_address <= '0;
      hit1 <= 1'b0;
      id1 <= '0;
      blank1 <= 1'b0;
      pix_index <= '0;
      pix_hit <= 1'b0;
      pix_id <= '0;
      pix_blank <= 1'b0;
      pix_highlight <= 1'b0;
      sel <= '0;
      sel_on <= 1'b0;
      cnt <= '0;
      blink_on <= 1'b1;
    end else begin
      rom_address <= vis ? d_addr : '0;
      hit1 <= vis;
      id1 <= vis ? d_id : '0;
      blank1 <= blank;
      pix_index <= hit1 ? rom_q : '0;
      pix_hit <= hit1;
      pix_id <= id1;
      pix_blank <= blank1;
      pix_highlight <= hit1 & sel_on & (id1 == sel) & blink_on;
      // Selection only moves at frame start so a frame never shows two highlights.
      if (frame_start) begin
        sel <= track_sel;
        sel_on <= 32'(track_sel) < 32'(NUM_SPRITES);
        cnt <= last_frame ? '0 : cnt + 1'b1;
        if (last_frame) blink_on <= ~blink_on;
      end
    end
endmodule

// File: tb/tb_sprite_fetch_scheduler.sv
// tb_sprite_fetch_scheduler: directed and random pixels checked against an arithmetic slot/blink model.
module tb_sprite_fetch_scheduler;
  localparam int NS = 4, W = 35, H = 58, X0 = 0, Y0 = 82, DY = 64, AW = 13, BF = 15;
  logic clk = 1'b0, reset_n = 1'b0, blank = 1'b0;
  logic [9:0] DrawX = '0, DrawY = '0;
  logic [2:0] track_sel = '0, pix_id;
  logic [AW-1:0] rom_address;
  logic [0:0] rom_q = '0, pix_index;
  logic pix_hit, pix_highlight, pix_blank;
  int n_chk = 0, n_fail = 0;
  int nf = 0, sel_m = -1;
  int p_hit = 0, p_id = 0, p_idx = 0, p_hl = 0, p_blank = 0;

  sprite_fetch_scheduler dut (
    .vga_clk(clk), .reset_n(reset_n), .DrawX(DrawX), .DrawY(DrawY), .blank(blank),
    .track_sel(track_sel), .rom_address(rom_address), .rom_q(rom_q), .pix_hit(pix_hit),
    .pix_id(pix_id), .pix_index(pix_index), .pix_highlight(pix_highlight), .pix_blank(pix_blank)
  );

  always #5 clk = ~clk;
  always @(negedge clk) rom_q <= rom_address[0:0];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, ".rom_address"}, 32'(rom_address), 0);
    chk({tag, ".pix_hit"}, 32'(pix_hit), 0);
    chk({tag, ".pix_id"}, 32'(pix_id), 0);
    chk({tag, ".pix_index"}, 32'(pix_index), 0);
    chk({tag, ".pix_highlight"}, 32'(pix_highlight), 0);
    chk({tag, ".pix_blank"}, 32'(pix_blank), 0);
  endtask

  // Slot = row band of pitch DY; inside the band only the first H rows are sprite.
  function automatic void ref_pix(input int x, input int y, input bit b,
                                  output int h, output int id, output int a);
    int r, oy;
    h = 0; id = 0; a = 0;
    if (b && x >= X0 && x < X0 + W && y >= Y0) begin
      r = (y - Y0) / DY;
      oy = (y - Y0) % DY;
      if (r < NS && oy < H) begin
        h = 1; id = r;
        a = (r * W * H + (x - X0) + oy * W) % (1 << AW);
      end
    end
  endfunction

  task automatic model_reset();
    nf = 0; sel_m = -1;
    p_hit = 0; p_id = 0; p_idx = 0; p_hl = 0; p_blank = 0;
  endtask

  task automatic step(input int x, input int y, input bit b);
    int h, id, a;
    DrawX = 10'(x); DrawY = 10'(y); blank = b;
    ref_pix(x, y, b, h, id, a);
    if (x == 0 && y == 0) begin
      sel_m = (track_sel < 3'(NS)) ? int'(track_sel) : -1;
      nf++;
    end
    @(posedge clk); #1;
    chk($sformatf("rom_address(%0d,%0d)", x, y), 32'(rom_address), a);
    chk("pix_hit", 32'(pix_hit), p_hit);
    chk("pix_id", 32'(pix_id), p_id);
    chk("pix_index", 32'(pix_index), p_idx);
    chk("pix_highlight", 32'(pix_highlight), p_hl);
    chk("pix_blank", 32'(pix_blank), p_blank);
    p_hit = h; p_id = id; p_idx = h ? a % 2 : 0; p_blank = b;
    p_hl = (h != 0 && id == sel_m && ((nf / BF) % 2) == 0) ? 1 : 0;
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1 chk_zero("reset");
    reset_n = 1'b1;
    model_reset();
    step(0, 82, 1);
    step(34, 139, 1);
    step(35, 139, 1);
    step(1, 146, 1);
    step(1, 145, 1);
    step(0, 139, 1);
    step(0, 140, 1);
    step(34, 140, 1);
    for (int x = 0; x < 40; x++) step(x, 100, 1);
    step(5, 150, 0);
    step(6, 150, 0);
    step(7, 150, 1);
    // Highlight: selection set mid-frame takes effect at the next frame start.
    track_sel = 3'd2;
    for (int x = 0; x < 4; x++) step(x, 220, 1);
    step(0, 0, 1);
    track_sel = 3'd0;
    for (int x = 0; x < 4; x++) step(x, 220, 1);
    step(3, 90, 1);
    step(0, 1, 1);
    step(1, 0, 1);
    track_sel = 3'd2;
    for (int f = 0; f < 14; f++) begin
      step(0, 0, 1);
      step(10, 230, 1);
    end
    step(11, 230, 1);
    for (int f = 0; f < 15; f++) begin
      step(0, 0, 1);
      step(10, 230, 1);
    end
    step(12, 300, 1);
    track_sel = 3'd5;
    step(0, 0, 1);
    step(12, 300, 1);
    step(12, 100, 1);
    for (int i = 0; i < 400; i++) begin
      track_sel = 3'($urandom_range(0, 7));
      if ($urandom_range(0, 19) == 0) step(0, 0, 1);
      else step($urandom_range(0, 45), $urandom_range(60, 360), $urandom_range(0, 5) != 0);
    end
    // Park the blink phase off, then reset mid-row; it must restart on.
    while (((nf / BF) % 2) == 0) step(0, 0, 1);
    track_sel = 3'd2;
    step(0, 0, 1);
    step(20, 240, 1);
    step(21, 240, 1);
    #2 reset_n = 1'b0;
    #1 chk_zero("async_reset");
    model_reset();
    #2 reset_n = 1'b1;
    step(0, 0, 1);
    step(22, 240, 1);
    step(23, 240, 1);
    step(24, 240, 1);
    step(0, 0, 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/sprite_fetch_scheduler.md
Name: sprite_fetch_scheduler

Overview:
- Shares one instrument-image ROM (all track sprites concatenated) among NUM_SPRITES on-screen sprite slots stacked vertically in the track-label column.
- Per pixel it decides which slot (if any) covers DrawX/DrawY and issues the shared ROM address. It then returns the palette index aligned with a slot id, a hit flag and a highlight flag.
- Sits between the VGA timing generator and the palette/colour mux. The ROM is clocked on ~vga_clk.

Parameters:
- NUM_SPRITES, 4, number of sprite slots/tracks (2..8)
- SPR_W, 35, sprite width in pixels
- SPR_H, 58, sprite height in pixels
- SPR_X0, 0, left edge of every slot
- SPR_Y0, 82, top edge of slot 0
- SPR_DY, 64, vertical pitch between slot tops; must be >= SPR_H
- ROM_AW, 13, ROM address width; must satisfy NUM_SPRITES*SPR_W*SPR_H <= 2^ROM_AW
- IDX_W, 1, palette index width
- BLINK_FRAMES, 15, frames per highlight blink half-period

Ports:
- vga_clk  in  1  pixel clock, all flops on posedge
- reset_n  in  1  asynchronous active-low reset
- DrawX  in  10  current pixel column
- DrawY  in  10  current pixel row
- blank  in  1  1 = visible pixel (active display)
- track_sel  in  3  selected track to highlight; values >= NUM_SPRITES mean none
- rom_address  out  ROM_AW  shared ROM address, registered
- rom_q  in  IDX_W  ROM data, valid one vga_clk after rom_address changes
- pix_hit  out  1  pixel lies inside a sprite slot
- pix_id  out  3  slot index of the hit
- pix_index  out  IDX_W  palette index for this pixel
- pix_highlight  out  1  hit slot is the selected track and blink phase is on
- pix_blank  out  1  blank delayed to align with the pix_* outputs

Behaviour:
- Reset (async, reset_n=0): all outputs 0, blink counter 0, blink phase 1, latched selection = none.
- Slot i covers these pixels:
  - SPR_X0 <= DrawX < SPR_X0+SPR_W
  - Yi <= DrawY < Yi+SPR_H, where Yi = SPR_Y0 + i*SPR_DY
- Priority when slots overlap: lowest index wins.
- Address for a hit on slot i: i*SPR_W*SPR_H + (DrawX-SPR_X0) + (DrawY-Yi)*SPR_W.
  - Compute at full width, truncate to ROM_AW.
  - Unsigned; never evaluated with negative offsets because hit detection gates it.
- Miss or blank=0: rom_address registers 0 and the stage-1 hit is 0.
- Stage 1 (posedge N) registers: rom_address, hit1, id1, blank1.
- The ROM samples on the negedge between N and N+1.
- Stage 2 (posedge N+1) registers:
  - pix_index = hit1 ? rom_q : 0
  - pix_hit = hit1
  - pix_id = id1
  - pix_blank = blank1
  - pix_highlight = hit1 & (id1 == sel_latched) & blink_on
- Fixed latency: 2 vga_clk from DrawX/DrawY to pix_*. No stalls.
- Frame start is the cycle where DrawX==0 and DrawY==0.
- At frame start:
  - track_sel is latched into sel_latched. It stays constant for the whole frame, so there is no mid-frame tearing.
  - The frame counter increments.
  - When the counter reaches BLINK_FRAMES-1 it wraps to 0 and blink_on toggles.
- A track_sel change away from frame start has no effect until the next frame start.
- If the coordinate skips (0,0), no frame is counted (no false counts).
- Pixels in the last row/column of a slot must hit; one past the last row/column must miss.
- Mid-operation reset: outputs go to 0 immediately. The first valid pix_* appears 2 cycles after release.
- Blink state restarts with blink_on=1.

Decomposition:
- Shared package sprite_pkg holds:
  - localparam SPR_BASE(i) function
  - slot geometry constants
  - typedef sprite_id_t (logic [2:0])
  - typedef pix_idx_t (logic [IDX_W-1:0])
- One sub-module, sprite_slot_decode (combinational):
  - inputs DrawX/DrawY
  - outputs hit, id, address
  - instantiated once; internally generate-loops over slots

Test Plan:
- Slot address: reset then release, blank=1, DrawX=0, DrawY=82 → rom_address=0 and pix_hit=1, pix_id=0 two cycles later. DrawX=34, DrawY=139 → rom_address=2029. DrawX=35 → pix_hit=0, rom_address=0.
- Second slot: DrawY=146, DrawX=1 → rom_address=2031, pix_id=1. DrawY=145 → miss.
- ROM alignment: model ROM with rom_q = address[0] sampled on negedge. Scan one row → pix_index matches address LSB exactly 2 cycles after the coordinate, with no skew.
- Blanking: blank=0 inside slot 1 → pix_hit=0, pix_index=0, pix_blank=0.
- Highlight: track_sel=2 set mid-frame → no highlight on slot 2 that frame; next frame, slot-2 pixels give pix_highlight=1. After 15 frame starts → 0. After 30 → 1.
- Async reset: assert reset_n mid-row → all outputs 0 the same cycle. Release → valid output resumes after 2 cycles, blink_on=1.
